// File: rtl/fetch_inflight_tracker_if.sv
// Fetch in-flight tracker bus: request issue, flush, sub-unit returns and decode response.
interface fetch_inflight_tracker_if #(
   parameter int unsigned DEPTH         = 2,
   parameter int unsigned NUM_SUB_UNITS = 3
);
   localparam int unsigned SUB_W = (NUM_SUB_UNITS > 1) ? $clog2(NUM_SUB_UNITS) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic                          req_valid;
   logic [SUB_W-1:0]              req_subunit;
   logic                          req_addr_valid;
   logic                          req_mmu_fault;
   logic [31:0]                   req_pc;
   logic                          req_ready;
   logic                          flush;
   logic [NUM_SUB_UNITS-1:0]      unit_data_valid;
   logic [NUM_SUB_UNITS*32-1:0]   unit_data;
   logic                          rsp_valid;
   logic [31:0]                   rsp_pc;
   logic [31:0]                   rsp_instr;
   logic                          rsp_ok;
   logic                          rsp_page_fault;
   logic                          flushing;
   logic [CNT_W-1:0]              inflight_count;
   logic                          spurious_rsp;

   modport master (
      output req_valid, req_subunit, req_addr_valid, req_mmu_fault, req_pc, flush,
             unit_data_valid, unit_data,
      input  req_ready, rsp_valid, rsp_pc, rsp_instr, rsp_ok, rsp_page_fault, flushing,
             inflight_count, spurious_rsp
   );

   modport slave (
      input  req_valid, req_subunit, req_addr_valid, req_mmu_fault, req_pc, flush,
             unit_data_valid, unit_data,
      output req_ready, rsp_valid, rsp_pc, rsp_instr, rsp_ok, rsp_page_fault, flushing,
             inflight_count, spurious_rsp
   );
endinterface

// File: rtl/fetch_inflight_tracker.sv
// In-order tracker of outstanding instruction fetches. Steers the owning sub-unit's
// returned word to decode in issue order and drops responses of pre-flush requests.
module fetch_inflight_tracker #(
   parameter int unsigned DEPTH         = 2,
   parameter int unsigned NUM_SUB_UNITS = 3
) (
   input logic                     clk,
   input logic                     rst,
   fetch_inflight_tracker_if.slave bus
);
   localparam int unsigned SUB_W = (NUM_SUB_UNITS > 1) ? $clog2(NUM_SUB_UNITS) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned PTR_W = IDX_W + 1;

   // Entry storage
   logic [31:0]              pc_q  [DEPTH];
   logic [SUB_W-1:0]         sub_q [DEPTH];
   logic                     av_q  [DEPTH];
   logic                     mf_q  [DEPTH];

   logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]         discard_q, discard_d;
   logic                     spurious_q, spurious_d;

   logic [IDX_W-1:0]         wr_idx, rd_idx;
   logic                     full, empty, push, pop;
   logic                     head_ok, head_strobe;
   logic [CNT_W-1:0]         count, count_next;
   logic [NUM_SUB_UNITS-1:0] head_mask;
   logic [31:0]              head_data;

   assign wr_idx = wr_ptr_q[IDX_W-1:0];
   assign rd_idx = rd_ptr_q[IDX_W-1:0];
   assign empty  = (wr_ptr_q == rd_ptr_q);
   // Same index with differing wrap bits means the writer has lapped the reader.
   assign full   = (wr_idx == rd_idx) && (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
   assign count  = CNT_W'(wr_ptr_q - rd_ptr_q);

   // Decode the head's sub-unit into a strobe mask and select its return word.
   always_comb begin
      head_mask = '0;
      head_data = '0;
      for (int i = 0; i < NUM_SUB_UNITS; i++) begin
         if (sub_q[rd_idx] == SUB_W'(i)) begin
            head_mask[i] = 1'b1;
            head_data    = bus.unit_data[32*i +: 32];
         end
      end
   end

   assign head_ok     = av_q[rd_idx] & ~mf_q[rd_idx];
   assign head_strobe = |(bus.unit_data_valid & head_mask);
   assign push        = bus.req_valid & ~full;
   // Faulting or unmapped entries expect no memory response and retire at once.
   assign pop         = ~empty & (head_ok ? head_strobe : 1'b1);
   assign count_next  = count + CNT_W'(push) - CNT_W'(pop);

   // Next-state for discard counter and spurious-response flag.
   always_comb begin
      discard_d = discard_q;
      if (bus.flush) begin
         // Everything still tracked after this cycle, including a same-cycle push, is stale.
         discard_d = count_next;
      end else if (pop && (discard_q != '0)) begin
         discard_d = discard_q - CNT_W'(1);
      end
      spurious_d = empty ? |bus.unit_data_valid : |(bus.unit_data_valid & ~head_mask);
   end

   // Pointer, discard and spurious state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         discard_q  <= '0;
         spurious_q <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         discard_q  <= discard_d;
         spurious_q <= spurious_d;
      end
   end

   // Capture request attributes on push; contents need no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_q[wr_idx]  <= bus.req_pc;
         sub_q[wr_idx] <= bus.req_subunit;
         av_q[wr_idx]  <= bus.req_addr_valid;
         mf_q[wr_idx]  <= bus.req_mmu_fault;
      end
   end

   assign bus.req_ready      = ~full;
   // A pop in a flush cycle belongs to a stale request.
   assign bus.rsp_valid      = pop & (discard_q == '0) & ~bus.flush;
   assign bus.rsp_pc         = pc_q[rd_idx];
   assign bus.rsp_instr      = head_ok ? head_data : 32'h0;
   assign bus.rsp_ok         = head_ok;
   assign bus.rsp_page_fault = mf_q[rd_idx];
   assign bus.flushing       = (discard_q != '0);
   assign bus.inflight_count = count;
   assign bus.spurious_rsp   = spurious_q;
endmodule

// File: tb/tb_fetch_inflight_tracker.sv
// Self-checking bench for fetch_inflight_tracker: vector table, corner-case sequences and
// randomized traffic, all checked against a queue-based reference model.
module tb_fetch_inflight_tracker;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned NSU   = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   tests  = 0;
   int   failed = 0;

   fetch_inflight_tracker_if #(.DEPTH(DEPTH), .NUM_SUB_UNITS(NSU)) bus ();

   fetch_inflight_tracker #(.DEPTH(DEPTH), .NUM_SUB_UNITS(NSU)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      int          sub;
      bit          av;
      bit          mf;
   } ent_t;

   typedef struct {
      bit          rv;
      int          sub;
      bit          av;
      bit          mf;
      logic [31:0] pc;
      bit          fl;
      logic [2:0]  udv;
      logic [31:0] word;
      bit          e_rv;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
      bit          e_ok;
      bit          e_pf;
      int          e_cnt;
   } vec_t;

   // Reference model: outstanding requests in issue order, stale-response budget, spurious flag.
   ent_t q[$];
   int   disc = 0;
   bit   spur = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, compare all outputs to the model, then advance the model.
   task automatic step(input bit rv, input int sub, input bit av, input bit mf,
                       input logic [31:0] pc, input bit fl, input logic [2:0] udv,
                       input logic [95:0] data);
      ent_t        h;
      bit          has, ok, pop, push, erv;
      logic [31:0] hdata;
      logic [2:0]  others;
      @(negedge clk);
      bus.req_valid       = rv;
      bus.req_subunit     = sub[1:0];
      bus.req_addr_valid  = av;
      bus.req_mmu_fault   = mf;
      bus.req_pc          = pc;
      bus.flush           = fl;
      bus.unit_data_valid = udv;
      bus.unit_data       = data;
      #1;
      has = (q.size() > 0);
      h   = '{pc: 32'h0, sub: 0, av: 1'b0, mf: 1'b0};
      if (has) h = q[0];
      ok    = has && h.av && !h.mf;
      hdata = data[h.sub*32 +: 32];
      pop   = has && (ok ? udv[h.sub] : 1'b1);
      push  = rv && (q.size() < DEPTH);
      erv   = pop && (disc == 0) && !fl;
      chk("req_ready", bus.req_ready, q.size() < DEPTH);
      chk("inflight_count", bus.inflight_count, q.size());
      chk("flushing", bus.flushing, disc != 0);
      chk("spurious_rsp", bus.spurious_rsp, spur);
      chk("rsp_valid", bus.rsp_valid, erv);
      if (erv) begin
         chk("rsp_pc", bus.rsp_pc, h.pc);
         chk("rsp_instr", bus.rsp_instr, ok ? hdata : 32'h0);
         chk("rsp_ok", bus.rsp_ok, ok);
         if (!ok) chk("rsp_page_fault", bus.rsp_page_fault, h.mf);
      end
      others = udv;
      if (has) others[h.sub] = 1'b0;
      spur = has ? (others != 3'b000) : (udv != 3'b000);
      if (pop) void'(q.pop_front());
      if (push) q.push_back('{pc: pc, sub: sub, av: av, mf: mf});
      if (fl) disc = q.size();
      else if (pop && disc > 0) disc--;
   endtask

   task automatic idle();
      step(1'b0, 0, 1'b0, 1'b0, 32'h0, 1'b0, 3'b000, 96'h0);
   endtask

   task automatic push_req(input int sub, input logic [31:0] pc);
      step(1'b1, sub, 1'b1, 1'b0, pc, 1'b0, 3'b000, 96'h0);
   endtask

   task automatic ret(input int sub, input logic [31:0] word);
      logic [2:0] u;
      u      = 3'b000;
      u[sub] = 1'b1;
      step(1'b0, 0, 1'b0, 1'b0, 32'h0, 1'b0, u, {3{word}});
   endtask

   vec_t vecs[12];

   initial begin
      bus.req_valid       = 1'b0;
      bus.req_subunit     = '0;
      bus.req_addr_valid  = 1'b0;
      bus.req_mmu_fault   = 1'b0;
      bus.req_pc          = '0;
      bus.flush           = 1'b0;
      bus.unit_data_valid = '0;
      bus.unit_data       = '0;

      // Reset values while rst is held low
      #12;
      chk("rst_ready", bus.req_ready, 1);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_flushing", bus.flushing, 0);
      chk("rst_count", bus.inflight_count, 0);
      chk("rst_spurious", bus.spurious_rsp, 0);
      @(negedge clk);
      rst = 1'b1;

      // Basic order on sub-unit 1, then MMU fault and access fault paths
      //          rv sub av mf pc            fl udv     word          e_rv e_pc          e_instr       ok pf cnt
      vecs[0]  = '{1, 1, 1, 0, 32'h100, 0, 3'b000, 32'h0,  0, 32'h0,   32'h0,  0, 0, 0};
      vecs[1]  = '{1, 1, 1, 0, 32'h104, 0, 3'b000, 32'h0,  0, 32'h0,   32'h0,  0, 0, 1};
      vecs[2]  = '{1, 1, 1, 0, 32'h108, 0, 3'b010, 32'hA,  1, 32'h100, 32'hA,  1, 0, 2};
      vecs[3]  = '{0, 0, 0, 0, 32'h0,   0, 3'b010, 32'hB,  1, 32'h104, 32'hB,  1, 0, 2};
      vecs[4]  = '{0, 0, 0, 0, 32'h0,   0, 3'b000, 32'h0,  0, 32'h0,   32'h0,  0, 0, 1};
      vecs[5]  = '{0, 0, 0, 0, 32'h0,   0, 3'b010, 32'hC,  1, 32'h108, 32'hC,  1, 0, 1};
      vecs[6]  = '{1, 0, 1, 1, 32'h200, 0, 3'b000, 32'h0,  0, 32'h0,   32'h0,  0, 0, 0};
      vecs[7]  = '{1, 0, 1, 0, 32'h204, 0, 3'b000, 32'h0,  1, 32'h200, 32'h0,  0, 1, 1};
      vecs[8]  = '{0, 0, 0, 0, 32'h0,   0, 3'b000, 32'h0,  0, 32'h0,   32'h0,  0, 0, 1};
      vecs[9]  = '{1, 2, 0, 0, 32'h300, 0, 3'b001, 32'h55, 1, 32'h204, 32'h55, 1, 0, 1};
      vecs[10] = '{0, 0, 0, 0, 32'h0,   0, 3'b000, 32'h0,  1, 32'h300, 32'h0,  0, 0, 1};
      vecs[11] = '{0, 0, 0, 0, 32'h0,   0, 3'b000, 32'h0,  0, 32'h0,   32'h0,  0, 0, 0};
      for (int i = 0; i < 12; i++) begin
         step(vecs[i].rv, vecs[i].sub, vecs[i].av, vecs[i].mf, vecs[i].pc, vecs[i].fl,
              vecs[i].udv, {3{vecs[i].word}});
         chk("tbl_rsp_valid", bus.rsp_valid, vecs[i].e_rv);
         chk("tbl_count", bus.inflight_count, vecs[i].e_cnt);
         if (vecs[i].e_rv) begin
            chk("tbl_rsp_pc", bus.rsp_pc, vecs[i].e_pc);
            chk("tbl_rsp_instr", bus.rsp_instr, vecs[i].e_instr);
            chk("tbl_rsp_ok", bus.rsp_ok, vecs[i].e_ok);
            if (!vecs[i].e_ok) chk("tbl_page_fault", bus.rsp_page_fault, vecs[i].e_pf);
         end
      end

      // Full: four entries block a fifth; one return frees a slot
      for (int i = 0; i < 4; i++) push_req(0, 32'h400 + 32'(4 * i));
      idle();
      chk("full_ready", bus.req_ready, 0);
      chk("full_count", bus.inflight_count, 4);
      push_req(0, 32'h500);
      chk("full_ignored_count", bus.inflight_count, 4);
      ret(0, 32'h11);
      chk("full_ret_rsp_pc", bus.rsp_pc, 32'h400);
      idle();
      chk("full_after_ready", bus.req_ready, 1);
      chk("full_after_count", bus.inflight_count, 3);
      for (int i = 0; i < 3; i++) ret(0, 32'h20 + 32'(i));
      idle();
      chk("full_drained", bus.inflight_count, 0);

      // Flush with a same-cycle push: four stale responses are swallowed
      for (int i = 0; i < 3; i++) push_req(1, 32'h600 + 32'(4 * i));
      step(1'b1, 1, 1'b1, 1'b0, 32'h60C, 1'b1, 3'b000, 96'h0);
      idle();
      chk("flush_flushing", bus.flushing, 1);
      for (int i = 0; i < 4; i++) begin
         ret(1, 32'hDEAD0000 + 32'(i));
         chk("flush_discard_rv", bus.rsp_valid, 0);
      end
      idle();
      chk("flush_done", bus.flushing, 0);
      push_req(1, 32'h700);
      ret(1, 32'h77);
      chk("flush_post_rv", bus.rsp_valid, 1);
      chk("flush_post_instr", bus.rsp_instr, 32'h77);

      // Spurious: strobe from a non-head sub-unit, then a strobe while empty
      push_req(0, 32'h800);
      step(1'b0, 0, 1'b0, 1'b0, 32'h0, 1'b0, 3'b100, 96'h0);
      chk("spur_no_pop", bus.rsp_valid, 0);
      idle();
      chk("spur_pulse", bus.spurious_rsp, 1);
      chk("spur_kept_head", bus.inflight_count, 1);
      idle();
      chk("spur_single", bus.spurious_rsp, 0);
      ret(0, 32'h88);
      idle();
      step(1'b0, 0, 1'b0, 1'b0, 32'h0, 1'b0, 3'b100, 96'h0);
      idle();
      chk("spur_empty", bus.spurious_rsp, 1);

      // Asynchronous reset mid-stream with two entries and flushing
      push_req(0, 32'h900);
      push_req(0, 32'h904);
      step(1'b0, 0, 1'b0, 1'b0, 32'h0, 1'b1, 3'b000, 96'h0);
      idle();
      chk("arst_pre_flushing", bus.flushing, 1);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_ready", bus.req_ready, 1);
      chk("arst_rsp_valid", bus.rsp_valid, 0);
      chk("arst_flushing", bus.flushing, 0);
      chk("arst_count", bus.inflight_count, 0);
      chk("arst_spurious", bus.spurious_rsp, 0);
      q.delete();
      disc = 0;
      spur = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      push_req(2, 32'hA00);
      idle();
      chk("arst_first_push", bus.inflight_count, 1);
      ret(2, 32'hAA);
      chk("arst_first_rv", bus.rsp_valid, 1);

      // Randomized traffic against the model
      for (int n = 0; n < 2000; n++) begin
         bit          rv, av, mf, fl;
         int          sub;
         logic [2:0]  udv;
         logic [95:0] data;
         rv  = ($urandom_range(0, 99) < 55);
         sub = $urandom_range(0, 2);
         av  = ($urandom_range(0, 9) != 0);
         mf  = ($urandom_range(0, 9) == 0);
         fl  = ($urandom_range(0, 19) == 0);
         udv = 3'b000;
         if (q.size() > 0 && $urandom_range(0, 1) == 1) udv[q[0].sub] = 1'b1;
         if ($urandom_range(0, 9) == 0) udv = udv | 3'($urandom_range(0, 7));
         data = {$urandom, $urandom, $urandom};
         step(rv, sub, av, mf, $urandom & 32'hFFFF_FFFC, fl, udv, data);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
